dmgplus_rom_arbiter: RTL
========================

// Module: dmgplus_rom_arbiter
// PURPOSE
//  Shares the single physical cartridge read path between two requesters:
//  port 0 (splash generator) and port 1 (system/CPU-side reader).
//  Captures single-byte read strobes and arbitrates round-robin.
//  Sequences the cart bus through setup, /RD strobe and hold phases at clk_8m.
//  Returns each byte to its requester with a rd/bsy/data handshake.
// PARAMETERS
//  SETUP_CYC  1  cycles the address is stable before cart_rd_n falls (>=1)
//  RD_CYC     3  cycles cart_rd_n is held low; data is sampled on the last one (>=1)
//  HOLD_CYC   1  cycles the address is held after cart_rd_n rises (>=1)
// PORTS
//  clk_8m        in   1   system clock, 8 MHz
//  rst           in   1   synchronous reset, active-high
//  p0_en         in   1   port 0 enable; when low, p0_rd is ignored
//  p0_addr       in   16  port 0 byte address, sampled when p0_rd=1
//  p0_rd         in   1   port 0 read strobe, one cycle
//  p0_bsy        out  1   port 0 busy (combinational, see below)
//  p0_data       out  8   port 0 read data; valid while p0_bsy=0 after a read
//  p1_addr       in   16  port 1 byte address
//  p1_rd         in   1   port 1 read strobe
//  p1_bsy        out  1   port 1 busy
//  p1_data       out  8   port 1 read data
//  cart_addr     out  16  cartridge address bus
//  cart_rd_n     out  1   cartridge /RD, active-low
//  cart_cs_n     out  1   cartridge /CS, low during an access with addr in 0xA000-0xBFFF
//  cart_data     in   8   cartridge data bus
// BEHAVIOUR
//  Reset values: cart_rd_n=1, cart_cs_n=1, cart_addr=0, pN_data=0.
//   Both pending flags clear, FSM in IDLE, last_grant=1 (port 0 wins first).
//  Reset mid-access: abort immediately. cart_rd_n rises on the next edge; no data is latched.
//  Capture: pN_rd=1 while pendN=0 sets pendN and latches addrN at the edge.
//   If pendN=1, a further pN_rd is dropped; the latched address is not overwritten.
//  Port 0: p0_rd is ignored while p0_en=0.
//   Clearing p0_en does not cancel an already pending or in-service port 0 read.
//  Busy: pN_bsy = pN_rd | pendN (combinational).
//   A requester therefore sees bsy=1 in the same cycle it strobes rd.
//  FSM states: IDLE -> SETUP -> STROBE -> HOLD -> IDLE.
//  IDLE: if any pendN is set, pick owner and load cart_addr from addrOwner; go to SETUP.
//   If only one port is pending, it is granted.
//   If both are pending, grant the port != last_grant; last_grant <= owner.
//  SETUP: SETUP_CYC cycles with cart_rd_n=1; cart_cs_n is driven per address.
//  STROBE: RD_CYC cycles with cart_rd_n=0.
//   At the last STROBE edge: pOwner_data <= cart_data and pendOwner <= 0.
//  HOLD: HOLD_CYC cycles with cart_rd_n=1, address held; cart_cs_n=1. Then IDLE.
//  Latency (defaults): rd at cycle T gives bsy=0 with valid data at T+6, if the port was idle.
//   A back-to-back grant to the other port reaches SETUP at T+8.
//  pN_data holds its value until that port's next completion.
//  A new pN_rd arriving while the FSM serves the other port queues via pendN.
//   Starvation is impossible: strict alternation applies under continuous load.
//  The phase counter is wide enough for max(SETUP_CYC, RD_CYC, HOLD_CYC).
//   It resets to 0 on each state entry.
//  Address 0xFFFF and wrap-around are passed through unmodified; no address arithmetic.
// TESTING
//  Single p0 read: p0_addr=0x0100 with p0_rd pulse, cart_data=0x44.
//   -> cart_rd_n low for exactly 3 cycles with cart_addr=0x0100.
//   -> p0_bsy=1 for cycles T..T+5; p0_data=0x44 from T+6.
//  Simultaneous rd on both ports after reset (p0=0x0134, p1=0x0200).
//   -> p0 is served first, then p1.
//   -> p1 data is valid 2 cycles after p0's access ends its HOLD + IDLE.
//  Continuous back-to-back requests from both ports for 10 reads each.
//   -> grants alternate 0,1,0,1...; every byte lands on the correct port.
//  p0_en=0 while p0_rd pulses -> no cart access, p0_bsy=1 only during the rd cycle itself.
//   p1 is unaffected.
//  Address 0xA123 -> cart_cs_n=0 during SETUP/STROBE only.
//   Address 0x4000 -> cart_cs_n stays 1.
//  rst asserted during STROBE -> next cycle cart_rd_n=1 and both bsy=0.
//   pN_data is reset to 0; the next read completes normally.

Source files
------------

// File: rtl/dmgplus_rom_arbiter.sv
// Cartridge read-path arbiter for the splash generator (port 0) and CPU reader (port 1).
// Round-robin grant, setup / strobe / hold bus sequencing at clk_8m.
module dmgplus_rom_arbiter #(
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned RD_CYC    = 3,
    parameter int unsigned HOLD_CYC  = 1
) (
    input  logic        clk_8m,
    input  logic        rst,
    input  logic        p0_en,
    input  logic [15:0] p0_addr,
    input  logic        p0_rd,
    output logic        p0_bsy,
    output logic [7:0]  p0_data,
    input  logic [15:0] p1_addr,
    input  logic        p1_rd,
    output logic        p1_bsy,
    output logic [7:0]  p1_data,
    output logic [15:0] cart_addr,
    output logic        cart_rd_n,
    output logic        cart_cs_n,
    input  logic [7:0]  cart_data
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } state_t;

    localparam int unsigned MAX_AB = (SETUP_CYC > RD_CYC) ? SETUP_CYC : RD_CYC;
    localparam int unsigned MAXC   = (MAX_AB > HOLD_CYC) ? MAX_AB : HOLD_CYC;
    localparam int unsigned CW     = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] RD_LAST    = CW'(RD_CYC - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          pend0_q;
    logic          pend1_q;
    logic [15:0]   addr0_q;
    logic [15:0]   addr1_q;
    logic          owner_q;
    logic          last_grant_q;
    logic [15:0]   cart_addr_q;
    logic          cart_rd_n_q;
    logic          cart_cs_n_q;
    logic [7:0]    p0_data_q;
    logic [7:0]    p1_data_q;

    logic          cap0;
    logic          cap1;
    logic          grant1_d;
    logic [15:0]   grant_addr_d;

    // Request capture qualifiers and the round-robin pick for the next grant.
    always_comb begin
        cap0         = p0_rd & p0_en & ~pend0_q;
        cap1         = p1_rd & ~pend1_q;
        grant1_d     = pend1_q & (~pend0_q | ~last_grant_q);
        grant_addr_d = grant1_d ? addr1_q : addr0_q;
    end

    // Request capture, bus sequencing FSM and read-data return.
    always_ff @(posedge clk_8m) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pend0_q      <= 1'b0;
            pend1_q      <= 1'b0;
            addr0_q      <= '0;
            addr1_q      <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cart_addr_q  <= '0;
            cart_rd_n_q  <= 1'b1;
            cart_cs_n_q  <= 1'b1;
            p0_data_q    <= '0;
            p1_data_q    <= '0;
        end else begin
            if (cap0) begin
                pend0_q <= 1'b1;
                addr0_q <= p0_addr;
            end
            if (cap1) begin
                pend1_q <= 1'b1;
                addr1_q <= p1_addr;
            end
            unique case (state_q)
                IDLE: begin
                    if (pend0_q | pend1_q) begin
                        owner_q      <= grant1_d;
                        last_grant_q <= grant1_d;
                        cart_addr_q  <= grant_addr_d;
                        cart_cs_n_q  <= ~(grant_addr_d[15:13] == 3'b101);
                        cnt_q        <= '0;
                        state_q      <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_q == SETUP_LAST) begin
                        cart_rd_n_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= STROBE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                STROBE: begin
                    if (cnt_q == RD_LAST) begin
                        cart_rd_n_q <= 1'b1;
                        cart_cs_n_q <= 1'b1;
                        if (owner_q) begin
                            p1_data_q <= cart_data;
                            pend1_q   <= 1'b0;
                        end else begin
                            p0_data_q <= cart_data;
                            pend0_q   <= 1'b0;
                        end
                        cnt_q   <= '0;
                        state_q <= HOLD;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign p0_bsy    = p0_rd | pend0_q;
    assign p1_bsy    = p1_rd | pend1_q;
    assign p0_data   = p0_data_q;
    assign p1_data   = p1_data_q;
    assign cart_addr = cart_addr_q;
    assign cart_rd_n = cart_rd_n_q;
    assign cart_cs_n = cart_cs_n_q;

endmodule
